// File: rtl/reg_bus_arbiter.sv
// Register-bus structs shared by the arbiter and the initiators/targets around it.
// Request carries address, direction, write data/strobes and valid.
// Response carries read data, error flag and ready.
package reg_bus_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// Round-robin arbiter sharing one register-bus target among NUM_REQ initiators.
// Latency: zero added cycles; requests and responses pass combinationally.
// Backpressure: grant is held until the target asserts ready or the watchdog aborts.
module reg_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 0,
  parameter type reg_req_t = reg_bus_arbiter_pkg::reg_req_t,
  parameter type reg_rsp_t = reg_bus_arbiter_pkg::reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i [NUM_REQ],
  output reg_rsp_t reg_rsp_o [NUM_REQ],
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     timeout_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic            rsp_en;
  logic [IdxW-1:0] rsp_idx;
  reg_rsp_t        rsp_sel;
  logic            to_hit;

  // Wrap-around increment of a port index.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NUM_REQ - 1)) ? '0 : i + IdxW'(1);
  endfunction

  // Watchdog fires only when enabled and the stall count reaches the limit.
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  // First valid requester searching upward from the round-robin pointer;
  // scanning downward lets the closest-to-pointer match win the last write.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IdxW-1:0] idx;
      idx = IdxW'((int'(ptr_q) + k) % int'(NUM_REQ));
      if (reg_req_i[idx].valid) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state, request forwarding and response selection.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    reg_req_o = '0;
    rsp_en    = 1'b0;
    rsp_idx   = '0;
    rsp_sel   = '0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          reg_req_o = reg_req_i[win_idx];
          rsp_en    = 1'b1;
          rsp_idx   = win_idx;
          rsp_sel   = reg_rsp_i;
          if (reg_rsp_i.ready) begin
            ptr_d = next_idx(win_idx);
          end else begin
            gnt_d   = win_idx;
            cnt_d   = CntW'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        reg_req_o = reg_req_i[gnt_q];
        if (!reg_req_i[gnt_q].valid) begin
          // Initiator withdrew its request: release the bus silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (to_hit) begin
          // Abort: hide the request from the target and answer with an error.
          reg_req_o.valid = 1'b0;
          rsp_en          = 1'b1;
          rsp_idx         = gnt_q;
          rsp_sel.error   = 1'b1;
          rsp_sel.ready   = 1'b1;
          timeout_o       = 1'b1;
          ptr_d           = next_idx(gnt_q);
          cnt_d           = '0;
          state_d         = IDLE;
        end else begin
          rsp_en  = 1'b1;
          rsp_idx = gnt_q;
          rsp_sel = reg_rsp_i;
          if (reg_rsp_i.ready) begin
            ptr_d   = next_idx(gnt_q);
            cnt_d   = '0;
            state_d = IDLE;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fan the selected response out to its owner; every other port sees zero.
  always_comb begin
    for (int p = 0; p < int'(NUM_REQ); p++) begin
      reg_rsp_o[p] = (rsp_en && (rsp_idx == IdxW'(p))) ? rsp_sel : '0;
    end
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
